uart_bus_master: RTL

- UART-driven debug initiator on the same 32-bit memory bus that the memory-mapped Device peripherals respond on.
- Receives command packets on rx and issues single Read or Write transfers on the bus.
- Returns the read data or a write acknowledge on tx.
- Requests the bus through a req/gnt handshake so that an external arbiter can stall the CPU during a transfer.

---
 rtl/uart_bus_master_if.sv | 21 ++
 rtl/uart_bus_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master_if.sv
// Single-transfer memory bus seen from a bus initiator: request/grant handshake
// plus one-cycle Read/Write strobes with address, write data and combinational read data.
interface uart_bus_master_if;
  logic        bus_req;
  logic        bus_gnt;
  logic        Read;
  logic        Write;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;

  modport master (
    output bus_req, Read, Write, Address, Write_data,
    input  bus_gnt, Read_data
  );

  modport slave (
    input  bus_req, Read, Write, Address, Write_data,
    output bus_gnt, Read_data
  );
endinterface

// File: rtl/uart_bus_master.sv
// UART debug initiator: 'R'/'W' command packets on rx become single bus transfers, answered on tx.
// Bus access 1 cycle after grant, response starts the next cycle; rx bytes are dropped while busy.
module uart_bus_master #(
  parameter int CLK_FREQ       = 110000000,
  parameter int BAUD_RATE      = 115200,
  parameter int TIMEOUT_CYCLES = 11000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  output logic               tx,
  output logic               busy,
  uart_bus_master_if.master  bus
);

  localparam int DIV  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] ACK_BYTE = 8'h4B;

  // ---------------------------------------------------------------- receiver
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t      rx_state_q, rx_state_d;
  logic           rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [7:0]     rx_sh_q, rx_sh_d;
  logic           rx_vld_q, rx_vld_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_vld_q   <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_vld_q   <= rx_vld_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_vld_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          // Line back high at mid start bit: treat as noise, not a frame.
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == DIV_M1) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == DIV_M1) begin
          rx_cnt_d   = '0;
          rx_vld_d   = rx_s2_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // -------------------------------------------------------- command engine
  typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, ACCESS, SEND} state_t;

  state_t         state_q, state_d;
  logic           is_wr_q, is_wr_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]  to_cnt_q, to_cnt_d;
  logic [31:0]    addr_sh_q, addr_sh_d;
  logic [31:0]    data_sh_q, data_sh_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    txbuf_q, txbuf_d;
  logic [1:0]     bytes_left_q, bytes_left_d;
  logic [9:0]     frame_q, frame_d;
  logic [3:0]     tx_bit_q, tx_bit_d;
  logic [CW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [7:0]     first_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      is_wr_q      <= 1'b0;
      byte_cnt_q   <= '0;
      to_cnt_q     <= '0;
      addr_sh_q    <= '0;
      data_sh_q    <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      txbuf_q      <= '0;
      bytes_left_q <= '0;
      frame_q      <= '1;
      tx_bit_q     <= '0;
      tx_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      is_wr_q      <= is_wr_d;
      byte_cnt_q   <= byte_cnt_d;
      to_cnt_q     <= to_cnt_d;
      addr_sh_q    <= addr_sh_d;
      data_sh_q    <= data_sh_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      txbuf_q      <= txbuf_d;
      bytes_left_q <= bytes_left_d;
      frame_q      <= frame_d;
      tx_bit_q     <= tx_bit_d;
      tx_cnt_q     <= tx_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    is_wr_d      = is_wr_q;
    byte_cnt_d   = byte_cnt_q;
    to_cnt_d     = to_cnt_q;
    addr_sh_d    = addr_sh_q;
    data_sh_d    = data_sh_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    txbuf_d      = txbuf_q;
    bytes_left_d = bytes_left_q;
    frame_d      = frame_q;
    tx_bit_d     = tx_bit_q;
    tx_cnt_d     = tx_cnt_q;
    first_byte   = is_wr_q ? ACK_BYTE : bus.Read_data[31:24];
    case (state_q)
      IDLE: begin
        if (rx_vld_q && (rx_sh_q == OP_READ || rx_sh_q == OP_WRITE)) begin
          is_wr_d    = (rx_sh_q == OP_WRITE);
          byte_cnt_d = '0;
          to_cnt_d   = '0;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (rx_vld_q) begin
          // Shadow register so an aborted packet leaves Address untouched.
          addr_sh_d  = {addr_sh_q[23:0], rx_sh_q};
          byte_cnt_d = byte_cnt_q + 2'd1;
          to_cnt_d   = '0;
          if (byte_cnt_q == 2'd3) begin
            if (is_wr_q) begin
              state_d = DATA;
            end else begin
              addr_d  = {addr_sh_q[23:0], rx_sh_q};
              state_d = REQ;
            end
          end
        end else if (to_cnt_q == TO_M1) begin
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (rx_vld_q) begin
          data_sh_d  = {data_sh_q[23:0], rx_sh_q};
          byte_cnt_d = byte_cnt_q + 2'd1;
          to_cnt_d   = '0;
          if (byte_cnt_q == 2'd3) begin
            addr_d  = addr_sh_q;
            wdata_d = {data_sh_q[23:0], rx_sh_q};
            state_d = REQ;
          end
        end else if (to_cnt_q == TO_M1) begin
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      REQ: begin
        if (bus.bus_gnt) state_d = ACCESS;
      end
      ACCESS: begin
        frame_d      = {1'b1, first_byte, 1'b0};
        tx_bit_d     = '0;
        tx_cnt_d     = '0;
        txbuf_d      = is_wr_q ? 32'h0 : {bus.Read_data[23:0], 8'h00};
        bytes_left_d = is_wr_q ? 2'd0 : 2'd3;
        state_d      = SEND;
      end
      SEND: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            // Next frame's start bit follows the stop bit with no idle gap.
            if (bytes_left_q != 2'd0) begin
              frame_d      = {1'b1, txbuf_q[31:24], 1'b0};
              txbuf_d      = {txbuf_q[23:0], 8'h00};
              bytes_left_d = bytes_left_q - 2'd1;
              tx_bit_d     = '0;
            end else begin
              frame_d = '1;
              state_d = IDLE;
            end
          end else begin
            frame_d  = {1'b1, frame_q[9:1]};
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx             = frame_q[0];
  assign busy           = (state_q != IDLE);
  assign bus.bus_req    = (state_q == REQ) || (state_q == ACCESS);
  assign bus.Read       = (state_q == ACCESS) && !is_wr_q;
  assign bus.Write      = (state_q == ACCESS) && is_wr_q;
  assign bus.Address    = addr_q;
  assign bus.Write_data = wdata_q;

endmodule
